wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
- Final (write-back) pipeline stage. Sits directly downstream of the memory stage and consumes its `ms_to_ws_valid` / `ms_to_ws_bus`.
- Retires one instruction per cycle:
  - drives the byte-masked register-file write port;
  - returns a forwarding bus to decode;
  - keeps a retired-instruction counter;
  - emits the debug commit trace, optionally through a small backpressuring FIFO.

Parameters:
- TRACE_DEPTH, 4, trace FIFO entries; power of two, >=2; used only with WB_TRACE_FIFO_EN.
- CNT_W, 32, width of `retired_cnt`.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- ms_to_ws_valid  in  1  memory stage presents an instruction
- ms_to_ws_bus  in  `MS_TO_WS_BUS_WD` (73)  {gr_we[72:69], dest[68:64], final_result[63:32], pc[31:0]}
- ws_allowin  out  1  stage can accept this cycle
- rf_we  out  4  per-byte register write enable
- rf_waddr  out  5  destination register
- rf_wdata  out  32  write data
- ws_forward_bus  out  `WS_FORWARD_BUS_WD` (41)  {fwd_valid[40:37], dest[36:32], result[31:0]}
- debug_wb_pc  out  32  committed PC
- debug_wb_rf_wen  out  4  committed byte enables
- debug_wb_rf_wnum  out  5  committed destination
- debug_wb_rf_wdata  out  32  committed data
- trace_valid  out  1  debug_wb_* holds a valid commit record
- trace_ready  in  1  trace consumer accepts the record
- retired_cnt  out  CNT_W  instructions retired since reset

Behaviour:
- Reset (reset==0, asynchronous):
  - ws_valid=0; bus register all-zero; retired_cnt=0; FIFO emptied.
  - All outputs are 0, except ws_allowin=1 (follows ~ws_valid).
- Capture:
  - When ws_allowin=1, ws_valid <= ms_to_ws_valid.
  - The bus is registered only when ms_to_ws_valid & ws_allowin.
  - One-cycle latency from memory-stage handoff to register-file write.
- Handshake:
  - ws_allowin = ~ws_valid | ws_ready_go.
  - retire = ws_valid & ws_ready_go.
  - No flush input: the memory stage already withholds valid on reflush.
- Register-file write:
  - rf_we = {4{retire}} & gr_we; rf_waddr = dest; rf_wdata = final_result.
  - Partial enables (lwl/lwr) pass through unchanged.
  - dest==0 is not masked; the register file ignores r0.
- Forwarding:
  - fwd_valid = {4{ws_valid}} & gr_we, asserted even when not ready_go, because the data is final.
  - dest and result fields are the registered values.
- retired_cnt:
  - Increments by 1 on every retire, including gr_we==0 instructions.
  - Wraps 2^CNT_W-1 -> 0.
- Trace record = {pc, gr_we as wen, dest, result}. One record per retire, gr_we==0 included.

Optional Feature:
- Macro: WB_TRACE_FIFO_EN.
- Defined:
  - Records are pushed into a TRACE_DEPTH FIFO (sub-module) on retire.
  - debug_wb_* show the head entry; trace_valid = ~empty; pop on trace_valid & trace_ready.
  - ws_ready_go = ~full | (trace_valid & trace_ready), i.e. push into a full FIFO is allowed only with a simultaneous pop.
  - Empty+push: trace_valid rises the next cycle; no bypass.
  - Push+pop on full: occupancy unchanged.
  - Push+pop on empty is impossible.
  - While stalled: rf_we=0, retired_cnt holds, ws_allowin=0.
- Undefined:
  - No FIFO; ws_ready_go=1; ws_allowin=1 always after reset.
  - debug_wb_pc = registered pc; debug_wb_rf_wen = rf_we; debug_wb_rf_wnum / debug_wb_rf_wdata = rf_waddr / rf_wdata.
  - trace_valid = ws_valid; trace_ready is ignored.

Decomposition:
- Shared header mycpu.h holds:
  - `MS_TO_WS_BUS_WD` (73) and `WS_FORWARD_BUS_WD` (41);
  - bus field-offset constants;
  - the trace-record width (73, equal to the bus width).
- One sub-module: wb_trace_fifo, parameterised by depth and width.
  - Read/write pointers plus a count; same clk / asynchronous active-low reset.
  - Instantiated only under WB_TRACE_FIFO_EN.

Test Plan:
- Reset mid-stream: drive reset=0 while ws_valid=1 and retired_cnt=7 -> same cycle: rf_we=0, ws_valid=0, retired_cnt=0, trace_valid=0; after release, the next instruction retires normally.
- Single instruction: gr_we=4'hF, dest=5, result=0x12345678, pc=0xBFC00000, valid one cycle -> next cycle rf_we=4'hF, rf_waddr=5, rf_wdata=0x12345678, debug_wb_pc=0xBFC00000, ws_forward_bus[40:37]=4'hF; the cycle after, retired_cnt=1.
- Partial write: gr_we=4'b0011, dest=9, result=0x0000ABCD -> rf_we=4'b0011; a store with gr_we=0 -> rf_we=0, retired_cnt still +1.
- Back-to-back: 8 consecutive valid instructions (no FIFO) -> 8 consecutive cycles of rf_we!=0; retired_cnt=8; ws_allowin constantly 1.
- FIFO backpressure (WB_TRACE_FIFO_EN, depth 4): trace_ready=0, stream 6 instructions -> 4 retire; the 5th is held in WB with rf_we=0 and ws_allowin=0. Raise trace_ready for one cycle -> head popped, 5th retires in that cycle, count stays 4.
- Counter wrap: force retired_cnt=32'hFFFFFFFF, retire one -> retired_cnt=0.

Source files
------------

// File: rtl/wb_stage_pkg.sv
// Shared bus widths, field offsets and record layouts for the write-back stage.
// The memory-to-write-back bus and the commit trace record are both 73 bits wide.
package wb_stage_pkg;

    localparam int unsigned MS_TO_WS_BUS_WD   = 73;
    localparam int unsigned WS_FORWARD_BUS_WD = 41;
    localparam int unsigned TRACE_REC_WD      = 73;

    localparam int unsigned BUS_PC_LSB     = 0;
    localparam int unsigned BUS_RESULT_LSB = 32;
    localparam int unsigned BUS_DEST_LSB   = 64;
    localparam int unsigned BUS_GR_WE_LSB  = 69;

    localparam int unsigned FWD_RESULT_LSB = 0;
    localparam int unsigned FWD_DEST_LSB   = 32;
    localparam int unsigned FWD_VALID_LSB  = 37;

    typedef struct packed {
        logic [3:0]  gr_we;
        logic [4:0]  dest;
        logic [31:0] result;
        logic [31:0] pc;
    } ms_to_ws_t;

    typedef struct packed {
        logic [3:0]  fwd_valid;
        logic [4:0]  dest;
        logic [31:0] result;
    } ws_forward_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [3:0]  wen;
        logic [4:0]  dest;
        logic [31:0] result;
    } trace_rec_t;

    function automatic trace_rec_t make_trace(input ms_to_ws_t b);
        trace_rec_t r;
        r.pc     = b.pc;
        r.wen    = b.gr_we;
        r.dest   = b.dest;
        r.result = b.result;
        return r;
    endfunction

endpackage

// File: rtl/wb_trace_fifo.sv
// Commit-trace FIFO: read/write pointers plus an occupancy count.
// Depth must be a power of two so the pointers wrap naturally.
module wb_trace_fifo #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 73
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [Width-1:0] push_data,
    input  logic             pop,
    output logic [Width-1:0] head_data,
    output logic             empty,
    output logic             full
);

    localparam int unsigned AW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CW = $clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(Depth));
    assign do_pop  = pop & ~empty;
    // A push into a full FIFO is legal only alongside a pop.
    assign do_push = push & (~full | do_pop);

    always_comb begin
        count_d = count_q;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            count_q <= count_d;
            if (do_push) wptr_q <= wptr_q + AW'(1);
            if (do_pop)  rptr_q <= rptr_q + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= push_data;
    end

    // Present zeros while empty so the trace outputs are quiet after reset.
    assign head_data = empty ? '0 : mem_q[rptr_q];

endmodule

// File: rtl/wb_stage.sv
// Write-back pipeline stage: register-file write, forwarding, retire counter, commit trace.
// Define WB_TRACE_FIFO_EN to route the commit trace through a backpressuring FIFO.
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int unsigned TRACE_DEPTH = 4,
    parameter int unsigned CNT_W       = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         ms_to_ws_valid,
    input  logic [MS_TO_WS_BUS_WD-1:0]   ms_to_ws_bus,
    output logic                         ws_allowin,
    output logic [3:0]                   rf_we,
    output logic [4:0]                   rf_waddr,
    output logic [31:0]                  rf_wdata,
    output logic [WS_FORWARD_BUS_WD-1:0] ws_forward_bus,
    output logic [31:0]                  debug_wb_pc,
    output logic [3:0]                   debug_wb_rf_wen,
    output logic [4:0]                   debug_wb_rf_wnum,
    output logic [31:0]                  debug_wb_rf_wdata,
    output logic                         trace_valid,
    input  logic                         trace_ready,
    output logic [CNT_W-1:0]             retired_cnt
);

    logic             ws_valid_q;
    ms_to_ws_t        ws_bus_q;
    logic             ws_ready_go;
    logic             retire;
    logic [CNT_W-1:0] retired_cnt_q;
    ws_forward_t      fwd;
    trace_rec_t       commit_rec;

    assign ws_allowin = ~ws_valid_q | ws_ready_go;
    assign retire     = ws_valid_q & ws_ready_go;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ws_valid_q <= 1'b0;
            ws_bus_q   <= '0;
        end else begin
            if (ws_allowin) ws_valid_q <= ms_to_ws_valid;
            if (ms_to_ws_valid && ws_allowin) ws_bus_q <= ms_to_ws_t'(ms_to_ws_bus);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retired_cnt_q <= '0;
        end else if (retire) begin
            retired_cnt_q <= retired_cnt_q + CNT_W'(1);
        end
    end

    assign retired_cnt = retired_cnt_q;

    assign rf_we    = {4{retire}} & ws_bus_q.gr_we;
    assign rf_waddr = ws_bus_q.dest;
    assign rf_wdata = ws_bus_q.result;

    // The result is final here, so forward even while the stage is stalled.
    always_comb begin
        fwd           = '0;
        fwd.fwd_valid = {4{ws_valid_q}} & ws_bus_q.gr_we;
        fwd.dest      = ws_bus_q.dest;
        fwd.result    = ws_bus_q.result;
    end

    assign ws_forward_bus = fwd;
    assign commit_rec     = make_trace(ws_bus_q);

`ifdef WB_TRACE_FIFO_EN
    logic [TRACE_REC_WD-1:0] head_raw;
    trace_rec_t              head_rec;
    logic                    fifo_empty, fifo_full, trace_pop;

    assign trace_valid = ~fifo_empty;
    assign trace_pop   = trace_valid & trace_ready;
    assign ws_ready_go = ~fifo_full | trace_pop;

    wb_trace_fifo #(
        .Depth (TRACE_DEPTH),
        .Width (TRACE_REC_WD)
    ) u_trace_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (retire),
        .push_data (commit_rec),
        .pop       (trace_pop),
        .head_data (head_raw),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign head_rec          = trace_rec_t'(head_raw);
    assign debug_wb_pc       = head_rec.pc;
    assign debug_wb_rf_wen   = head_rec.wen;
    assign debug_wb_rf_wnum  = head_rec.dest;
    assign debug_wb_rf_wdata = head_rec.result;
`else
    localparam int unsigned unused_trace_depth = TRACE_DEPTH;
    logic unused_trace_ready;

    assign unused_trace_ready = trace_ready;
    assign ws_ready_go        = 1'b1;
    assign trace_valid        = ws_valid_q;
    assign debug_wb_pc        = commit_rec.pc;
    assign debug_wb_rf_wen    = rf_we;
    assign debug_wb_rf_wnum   = rf_waddr;
    assign debug_wb_rf_wdata  = rf_wdata;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: table vectors, random stream against a reference model,
// reset mid-stream, counter wrap on a narrow-counter instance, and FIFO backpressure.
module tb_wb_stage;
    import wb_stage_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        ms_to_ws_valid;
    ms_to_ws_t   in_bus;
    logic        trace_ready;

    logic        ws_allowin, trace_valid;
    logic [3:0]  rf_we, debug_wb_rf_wen;
    logic [4:0]  rf_waddr, debug_wb_rf_wnum;
    logic [31:0] rf_wdata, debug_wb_pc, debug_wb_rf_wdata, retired_cnt;
    logic [40:0] ws_forward_bus;

    logic        s_allowin, s_trace_valid;
    logic [3:0]  s_rf_we, s_wen;
    logic [4:0]  s_waddr, s_wnum;
    logic [31:0] s_wdata, s_pc, s_dwdata;
    logic [40:0] s_fwd;
    logic [2:0]  s_cnt;

    always #5 clk = ~clk;

    wb_stage #(.TRACE_DEPTH(4), .CNT_W(32)) dut (
        .clk (clk), .reset (reset),
        .ms_to_ws_valid (ms_to_ws_valid), .ms_to_ws_bus (in_bus),
        .ws_allowin (ws_allowin), .rf_we (rf_we), .rf_waddr (rf_waddr), .rf_wdata (rf_wdata),
        .ws_forward_bus (ws_forward_bus), .debug_wb_pc (debug_wb_pc),
        .debug_wb_rf_wen (debug_wb_rf_wen), .debug_wb_rf_wnum (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata), .trace_valid (trace_valid),
        .trace_ready (trace_ready), .retired_cnt (retired_cnt)
    );

    // Narrow counter so wrap-around is reachable in a short run.
    wb_stage #(.TRACE_DEPTH(4), .CNT_W(3)) dut_small (
        .clk (clk), .reset (reset),
        .ms_to_ws_valid (ms_to_ws_valid), .ms_to_ws_bus (in_bus),
        .ws_allowin (s_allowin), .rf_we (s_rf_we), .rf_waddr (s_waddr), .rf_wdata (s_wdata),
        .ws_forward_bus (s_fwd), .debug_wb_pc (s_pc),
        .debug_wb_rf_wen (s_wen), .debug_wb_rf_wnum (s_wnum),
        .debug_wb_rf_wdata (s_dwdata), .trace_valid (s_trace_valid),
        .trace_ready (trace_ready), .retired_cnt (s_cnt)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Reference model: what the stage holds and how many instructions have left it.
    logic        m_valid;
    ms_to_ws_t   m_bus;
    int unsigned m_cnt;

    task automatic model_reset();
        m_valid = 1'b0;
        m_bus   = '0;
        m_cnt   = 0;
    endtask

    // Advance one cycle; only valid while the trace path never stalls.
    task automatic tick();
        if (m_valid) m_cnt++;
        m_valid = ms_to_ws_valid;
        if (ms_to_ws_valid) m_bus = in_bus;
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        logic [3:0] exp_we;
        exp_we = m_valid ? m_bus.gr_we : 4'h0;
        chk({tag, ".rf_we"}, 64'(rf_we), 64'(exp_we));
        chk({tag, ".rf_waddr"}, 64'(rf_waddr), 64'(m_bus.dest));
        chk({tag, ".rf_wdata"}, 64'(rf_wdata), 64'(m_bus.result));
        chk({tag, ".fwd"}, 64'(ws_forward_bus), 64'({exp_we, m_bus.dest, m_bus.result}));
        chk({tag, ".cnt"}, 64'(retired_cnt), 64'(m_cnt));
        chk({tag, ".cnt3"}, 64'(s_cnt), 64'(m_cnt % 8));
        chk({tag, ".allowin"}, 64'(ws_allowin), 64'(1));
`ifndef WB_TRACE_FIFO_EN
        chk({tag, ".trace_valid"}, 64'(trace_valid), 64'(m_valid));
        chk({tag, ".dbg_pc"}, 64'(debug_wb_pc), 64'(m_bus.pc));
        chk({tag, ".dbg_wen"}, 64'(debug_wb_rf_wen), 64'(exp_we));
        chk({tag, ".dbg_wnum"}, 64'(debug_wb_rf_wnum), 64'(m_bus.dest));
        chk({tag, ".dbg_wdata"}, 64'(debug_wb_rf_wdata), 64'(m_bus.result));
`endif
    endtask

    task automatic do_reset();
        reset          = 1'b0;
        ms_to_ws_valid = 1'b0;
        in_bus         = '0;
        trace_ready    = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst.allowin", 64'(ws_allowin), 64'(1));
        chk("rst.rf_we", 64'(rf_we), 64'(0));
        chk("rst.fwd", 64'(ws_forward_bus), 64'(0));
        chk("rst.dbg_pc", 64'(debug_wb_pc), 64'(0));
        chk("rst.trace_valid", 64'(trace_valid), 64'(0));
        chk("rst.cnt", 64'(retired_cnt), 64'(0));
        reset = 1'b1;
    endtask

    function automatic ms_to_ws_t mk(input logic [3:0] we, input logic [4:0] d,
                                     input logic [31:0] r, input logic [31:0] pc);
        ms_to_ws_t b;
        b.gr_we  = we;
        b.dest   = d;
        b.result = r;
        b.pc     = pc;
        return b;
    endfunction

    typedef struct {
        logic        v;
        logic [3:0]  we;
        logic [4:0]  dest;
        logic [31:0] res;
        logic [31:0] pc;
        logic [3:0]  e_we;
        logic [4:0]  e_waddr;
        logic [31:0] e_wdata;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t tbl[5];

    initial begin
        tbl[0] = '{1'b1, 4'hF, 5'd5,  32'h12345678, 32'hBFC00000, 4'hF, 5'd5,  32'h12345678, 0};
        tbl[1] = '{1'b1, 4'h3, 5'd9,  32'h0000ABCD, 32'hBFC00004, 4'h3, 5'd9,  32'h0000ABCD, 1};
        tbl[2] = '{1'b1, 4'h0, 5'd0,  32'h00000000, 32'hBFC00008, 4'h0, 5'd0,  32'h00000000, 2};
        tbl[3] = '{1'b0, 4'hF, 5'd7,  32'hDEADBEEF, 32'h00000000, 4'h0, 5'd0,  32'h00000000, 3};
        tbl[4] = '{1'b1, 4'h8, 5'd31, 32'hAABBCCDD, 32'hBFC0000C, 4'h8, 5'd31, 32'hAABBCCDD, 3};

        do_reset();

        for (int i = 0; i < 5; i++) begin
            ms_to_ws_valid = tbl[i].v;
            in_bus = mk(tbl[i].we, tbl[i].dest, tbl[i].res, tbl[i].pc);
            tick();
            chk($sformatf("tbl%0d.rf_we", i), 64'(rf_we), 64'(tbl[i].e_we));
            chk($sformatf("tbl%0d.waddr", i), 64'(rf_waddr), 64'(tbl[i].e_waddr));
            chk($sformatf("tbl%0d.wdata", i), 64'(rf_wdata), 64'(tbl[i].e_wdata));
            chk($sformatf("tbl%0d.cnt", i), 64'(retired_cnt), 64'(tbl[i].e_cnt));
            check_model($sformatf("tbl%0d", i));
        end
        ms_to_ws_valid = 1'b0;
        tick();
        chk("tbl.cnt_final", 64'(retired_cnt), 64'(4));

        // Back-to-back stream of eight writing instructions.
        for (int i = 0; i < 8; i++) begin
            ms_to_ws_valid = 1'b1;
            in_bus = mk(4'($urandom_range(1, 15)), 5'($urandom), $urandom, 32'h1000 + 32'(i * 4));
            tick();
            chk("b2b.we_nonzero", 64'(rf_we != 4'h0), 64'(1));
            chk("b2b.allowin", 64'(ws_allowin), 64'(1));
        end
        ms_to_ws_valid = 1'b0;
        tick();
        chk("b2b.cnt", 64'(retired_cnt), 64'(12));
        chk("b2b.cnt3_wrapped", 64'(s_cnt), 64'(4));

        // Random stream against the model; the narrow counter wraps many times.
        for (int i = 0; i < 200; i++) begin
            ms_to_ws_valid = 1'($urandom);
            in_bus = mk(4'($urandom), 5'($urandom), $urandom, $urandom);
            tick();
            check_model("rnd");
        end

        // Reset asserted mid-cycle with an instruction in WB and seven retired.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            ms_to_ws_valid = 1'b1;
            in_bus = mk(4'hF, 5'(i + 1), 32'(i), 32'h2000 + 32'(i * 4));
            tick();
        end
        chk("mid.cnt_before", 64'(retired_cnt), 64'(7));
        chk("mid.valid_before", 64'(rf_we), 64'(4'hF));
        #2;
        reset = 1'b0;
        #1;
        chk("mid.rf_we", 64'(rf_we), 64'(0));
        chk("mid.trace_valid", 64'(trace_valid), 64'(0));
        chk("mid.cnt", 64'(retired_cnt), 64'(0));
        chk("mid.allowin", 64'(ws_allowin), 64'(1));
        chk("mid.fwd", 64'(ws_forward_bus), 64'(0));
        model_reset();
        ms_to_ws_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        ms_to_ws_valid = 1'b1;
        in_bus = mk(4'h5, 5'd3, 32'hCAFEF00D, 32'hBFC00100);
        tick();
        check_model("post_rst");
        ms_to_ws_valid = 1'b0;
        tick();
        check_model("post_rst2");

`ifdef WB_TRACE_FIFO_EN
        // Backpressure: four records fill the FIFO, the fifth waits in WB.
        do_reset();
        trace_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            ms_to_ws_valid = 1'b1;
            in_bus = mk(4'hF, 5'(k), 32'(k), 32'h100 + 32'(k * 4));
            @(posedge clk);
            #1;
        end
        in_bus = mk(4'hF, 5'd6, 32'd6, 32'h118);
        @(posedge clk);
        #1;
        chk("bp.rf_we_stalled", 64'(rf_we), 64'(0));
        chk("bp.allowin", 64'(ws_allowin), 64'(0));
        chk("bp.cnt", 64'(retired_cnt), 64'(4));
        chk("bp.trace_valid", 64'(trace_valid), 64'(1));
        chk("bp.head_pc", 64'(debug_wb_pc), 64'(32'h104));
        chk("bp.fwd_stalled", 64'(ws_forward_bus[40:37]), 64'(4'hF));
        trace_ready = 1'b1;
        #1;
        chk("bp.rf_we_release", 64'(rf_we), 64'(4'hF));
        chk("bp.allowin_release", 64'(ws_allowin), 64'(1));
        @(posedge clk);
        #1;
        trace_ready    = 1'b0;
        ms_to_ws_valid = 1'b0;
        chk("bp.cnt_after", 64'(retired_cnt), 64'(5));
        chk("bp.head_pc2", 64'(debug_wb_pc), 64'(32'h108));
        chk("bp.rf_we_6th", 64'(rf_we), 64'(0));
        trace_ready = 1'b1;
        for (int k = 2; k <= 6; k++) begin
            chk($sformatf("drain%0d.pc", k), 64'(debug_wb_pc), 64'(32'h100 + 32'(k * 4)));
            chk($sformatf("drain%0d.wnum", k), 64'(debug_wb_rf_wnum), 64'(k));
            @(posedge clk);
            #1;
        end
        chk("drain.empty", 64'(trace_valid), 64'(0));
        chk("drain.cnt", 64'(retired_cnt), 64'(6));
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
